// File: rtl/ring_osc_sweep_ctrl.sv
// Tapped ring-oscillator sequencer: steps the tap select, gates the ring on,
// counts synchronized rising edges of the divided ring output and reports per-tap counts.
module ring_osc_sweep_ctrl #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int OFF_CYCLES    = 2,
    parameter int CNT_W         = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_sweep,
    input  logic [3:0]       tap_sel,
    output logic             ring_ena,
    output logic [3:0]       ring_tap,
    input  logic             ring_div,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [3:0]       meas_tap,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_ovf,
    output logic             busy,
    output logic             done
);
    localparam int TMAX_GS = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMAX    = (TMAX_GS > OFF_CYCLES) ? TMAX_GS : OFF_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, OFF, SETTLE, GATE, REPORT} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
    logic             ovf_q, ovf_d, ovf_upd;
    logic             sweep_q, sweep_d;
    logic [3:0]       tap_q, tap_d;
    logic [3:0]       mtap_q, mtap_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             movf_q, movf_d;
    logic             done_q, done_d;
    logic             sync1, sync2, sync3;
    logic             rise, cnt_sat;

    assign rise    = sync2 & ~sync3;
    assign cnt_sat = &cnt_q;
    // Saturating counter: a rise arriving at all-ones marks the window as overflowed.
    assign cnt_upd = (rise && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
    assign ovf_upd = ovf_q | (rise & cnt_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sweep_q <= 1'b0;
            tap_q   <= '0;
            mtap_q  <= '0;
            mcnt_q  <= '0;
            movf_q  <= 1'b0;
            done_q  <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sweep_q <= sweep_d;
            tap_q   <= tap_d;
            mtap_q  <= mtap_d;
            mcnt_q  <= mcnt_d;
            movf_q  <= movf_d;
            done_q  <= done_d;
            sync1   <= ring_div;
            sync2   <= sync1;
            sync3   <= sync2;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sweep_d = sweep_q;
        tap_d   = tap_q;
        mtap_d  = mtap_q;
        mcnt_d  = mcnt_q;
        movf_d  = movf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sweep_d = mode_sweep;
                    tap_d   = mode_sweep ? 4'd0 : tap_sel;
                    tcnt_d  = '0;
                    state_d = OFF;
                end
            end
            OFF: begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == TW'(OFF_CYCLES - 1)) begin
                    tcnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == TW'(SETTLE_CYCLES - 1)) begin
                    tcnt_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = GATE;
                end
            end
            GATE: begin
                tcnt_d = tcnt_q + 1'b1;
                cnt_d  = cnt_upd;
                ovf_d  = ovf_upd;
                // Last window cycle: publish the updated count so its rise is included.
                if (tcnt_q == TW'(GATE_CYCLES - 1)) begin
                    tcnt_d  = '0;
                    mcnt_d  = cnt_upd;
                    movf_d  = ovf_upd;
                    mtap_d  = tap_q;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (meas_ready) begin
                    if (sweep_q && tap_q != 4'd15) begin
                        tap_d   = tap_q + 4'd1;
                        state_d = OFF;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort beats start and any same-cycle handshake; the tap is kept.
        if (abort) begin
            state_d = IDLE;
            tcnt_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            sweep_d = sweep_q;
            tap_d   = tap_q;
            done_d  = 1'b0;
        end
    end

    assign ring_ena   = (state_q == SETTLE) || (state_q == GATE);
    assign ring_tap   = tap_q;
    assign meas_valid = (state_q == REPORT);
    assign meas_tap   = mtap_q;
    assign meas_count = mcnt_q;
    assign meas_ovf   = movf_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_ring_osc_sweep_ctrl.sv
// Directed bench for ring_osc_sweep_ctrl: default instance for timing/sweep/abort/reset,
// a narrow-counter instance for saturation.
`timescale 1ns/1ps
module tb_ring_osc_sweep_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, mode_sweep, ring_div, meas_ready;
    logic [3:0]  tap_sel;
    logic        ring_ena, meas_valid, meas_ovf, busy, done;
    logic [3:0]  ring_tap, meas_tap;
    logic [11:0] meas_count;

    logic        start1, abort1, mode1, ring_div1, ready1, ov_run;
    logic [3:0]  tap1;
    logic        ring_ena1, meas_valid1, meas_ovf1, busy1, done1;
    logic [3:0]  ring_tap1, meas_tap1;
    logic [3:0]  meas_count1;

    int checks = 0, failures = 0;
    int done_cnt = 0, viol = 0;

    ring_osc_sweep_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_sweep(mode_sweep),
        .tap_sel(tap_sel), .ring_ena(ring_ena), .ring_tap(ring_tap), .ring_div(ring_div),
        .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_tap(meas_tap),
        .meas_count(meas_count), .meas_ovf(meas_ovf), .busy(busy), .done(done));

    ring_osc_sweep_ctrl #(.CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mode_sweep(mode1),
        .tap_sel(tap1), .ring_ena(ring_ena1), .ring_tap(ring_tap1), .ring_div(ring_div1),
        .meas_valid(meas_valid1), .meas_ready(ready1), .meas_tap(meas_tap1),
        .meas_count(meas_count1), .meas_ovf(meas_ovf1), .busy(busy1), .done(done1));

    // 10-clk period ring model, phase offset from clk
    initial begin
        ring_div = 1'b0;
        #2;
        forever #50 ring_div = ~ring_div;
    end

    // 4-clk period ring model for the narrow instance, parked low when ov_run=0
    initial begin
        ring_div1 = 1'b0;
        #3;
        forever begin
            #20;
            ring_div1 = ov_run ? ~ring_div1 : 1'b0;
        end
    end

    // Tap-change safety monitor and done pulse counter
    logic [3:0] ptap = 4'd0;
    logic       pena = 1'b0;
    int         after_chg = 0;
    bit         armed = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done) done_cnt++;
            if (ring_tap !== ptap) begin
                if (ring_ena || pena) viol++;
                armed = 1'b1;
                after_chg = 0;
            end
            if (!ring_ena && armed) after_chg++;
            if (ring_ena && !pena && armed) begin
                if (after_chg < 2) viol++;
                armed = 1'b0;
            end
        end
        ptap = ring_tap;
        pena = ring_ena;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start(input int inst);
        @(negedge clk);
        if (inst == 0) start = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start1 = 1'b0;
    endtask

    // n counts the current cycle as 1 and stops on the cycle meas_valid is seen
    task automatic wait_v(input int inst, input int limit, output int n);
        n = 1;
        while (!(inst == 0 ? meas_valid : meas_valid1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(inst == 0 ? meas_valid : meas_valid1), 32'd1);
    endtask

    int n, k, base;
    logic [31:0] snap;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_sweep = 1'b0; tap_sel = 4'd0;
        meas_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; mode1 = 1'b0; tap1 = 4'd0; ready1 = 1'b0; ov_run = 1'b0;
        #23;
        chk("reset_outputs", 32'({ring_ena, ring_tap, meas_valid, meas_tap, meas_count,
                                  meas_ovf, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tap 5
        tap_sel = 4'd5;
        pulse_start(0);
        wait_v(0, 3000, n);
        chk("single_latency", 32'(n), 32'd1043);
        chk("single_tap", 32'(meas_tap), 32'd5);
        chk_rng("single_count", 32'(meas_count), 102, 103);
        chk("single_ovf", 32'(meas_ovf), 32'd0);
        chk("single_report_ena", 32'(ring_ena), 32'd0);
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        chk("single_valid_drop", 32'(meas_valid), 32'd0);
        chk("single_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("single_done_pulse", 32'({done, busy}), 32'd0);

        // Sweep with ready tied high
        base = done_cnt;
        mode_sweep = 1'b1; tap_sel = 4'd9; meas_ready = 1'b1;
        pulse_start(0);
        for (int t = 0; t < 16; t++) begin
            wait_v(0, 3000, n);
            chk("sweep_latency", 32'(n), 32'd1043);
            chk("sweep_tap", 32'(meas_tap), 32'(t));
            chk_rng("sweep_count", 32'(meas_count), 102, 103);
            @(negedge clk);
        end
        chk("sweep_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("sweep_idle", 32'(busy), 32'd0);
        chk("sweep_done_count", 32'(done_cnt - base), 32'd1);
        chk("tap_change_safety", 32'(viol), 32'd0);

        // Backpressure on tap 0, then abort mid-GATE of tap 7
        meas_ready = 1'b0;
        pulse_start(0);
        wait_v(0, 3000, n);
        snap = 32'({meas_valid, meas_tap, meas_count, meas_ovf, ring_ena, ring_tap, busy});
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("bp_stable", 32'({meas_valid, meas_tap, meas_count, meas_ovf, ring_ena,
                                  ring_tap, busy}), snap);
        end
        meas_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 32'(meas_valid), 32'd0);
        chk("bp_next_tap", 32'(ring_tap), 32'd1);
        chk("bp_next_off", 32'(ring_ena), 32'd0);
        k = 0;
        while (!(ring_tap == 4'd7 && ring_ena) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_tap7", 32'({ring_tap, ring_ena}), 32'({4'd7, 1'b1}));
        repeat (100) @(negedge clk);
        base = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        meas_ready = 1'b0;
        chk("abort_idle", 32'({busy, ring_ena, meas_valid, done}), 32'd0);
        chk("abort_tap_kept", 32'(ring_tap), 32'd7);
        k = 0;
        repeat (1100) begin
            @(negedge clk);
            if (meas_valid || busy) k++;
        end
        chk("abort_quiet", 32'(k), 32'd0);
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);

        // Single tap 3 after abort
        mode_sweep = 1'b0; tap_sel = 4'd3;
        pulse_start(0);
        wait_v(0, 3000, n);
        chk("post_abort_latency", 32'(n), 32'd1043);
        chk("post_abort_tap", 32'(meas_tap), 32'd3);
        chk_rng("post_abort_count", 32'(meas_count), 102, 103);
        chk("post_abort_ovf", 32'(meas_ovf), 32'd0);
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        chk("post_abort_done", 32'(done), 32'd1);

        // Async reset while in REPORT
        tap_sel = 4'd12;
        pulse_start(0);
        wait_v(0, 3000, n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({ring_ena, ring_tap, meas_valid, meas_tap, meas_count,
                                meas_ovf, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        n = 1;
        while (!meas_valid && n < 3000) begin
            if (n == 500) begin
                tap_sel = 4'd2; mode_sweep = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; mode_sweep = 1'b0;
        chk("busy_start_latency", 32'(n), 32'd1043);
        chk("busy_start_tap", 32'(meas_tap), 32'd12);
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        chk("busy_start_done", 32'({done, meas_valid}), 32'({1'b1, 1'b0}));

        // Saturation on the 4-bit instance, then a quiet tap must read clean
        mode1 = 1'b1; ov_run = 1'b1;
        pulse_start(1);
        wait_v(1, 3000, n);
        chk("ovf_latency", 32'(n), 32'd1043);
        chk("ovf_count", 32'(meas_count1), 32'd15);
        chk("ovf_flag", 32'(meas_ovf1), 32'd1);
        chk("ovf_tap", 32'(meas_tap1), 32'd0);
        ov_run = 1'b0;
        @(negedge clk);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        wait_v(1, 3000, n);
        chk("clr_tap", 32'(meas_tap1), 32'd1);
        chk("clr_count", 32'(meas_count1), 32'd0);
        chk("clr_ovf", 32'(meas_ovf1), 32'd0);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("ovf_abort_idle", 32'({busy1, meas_valid1, ring_ena1, done1}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_osc_sweep_ctrl.md
Name: ring_osc_sweep_ctrl

Overview:
- Sequences the tapped ring oscillator: drives its enable and 4-bit tap select, and measures ring frequency per tap.
- Ring output is divided down outside this block and arrives on ring_div, asynchronous to clk.
- Rising edges of ring_div are counted over a fixed clk gate window.
- Supports single-tap measurement or a full sweep of taps 0..15; each result is presented on a valid/ready handshake to a host or readout block.

Parameters:
- GATE_CYCLES, 1024: clk cycles per counting window; must be >= 2.
- SETTLE_CYCLES, 16: clk cycles after ring enable before counting starts; must be >= 3.
- OFF_CYCLES, 2: clk cycles ring_ena is held low around every tap change; must be >= 1.
- CNT_W, 12: width of the edge counter and of meas_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a measurement when IDLE.
- abort  in  1  level; forces return to IDLE.
- mode_sweep  in  1  1 = sweep taps 0..15; 0 = single tap_sel. Sampled at start.
- tap_sel  in  4  tap for single mode. Sampled at start.
- ring_ena  out  1  ring oscillator enable.
- ring_tap  out  4  ring oscillator tap select.
- ring_div  in  1  divided ring output, asynchronous.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts the result.
- meas_tap  out  4  tap the result belongs to.
- meas_count  out  CNT_W  rising-edge count in the window.
- meas_ovf  out  1  count saturated.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, rst_n low) values:
  - all outputs 0, state IDLE;
  - synchronizer flops and edge-detect register 0;
  - internal counters 0.
- Synchronizer: ring_div passes through 2 flops, then a third flop for edge detect. A rise is sync2 & ~sync3.
- States:
  - IDLE: ring_ena=0. On start, latch mode_sweep; latch the tap (tap_sel, or 0 in sweep mode) into ring_tap; go to OFF. start while busy is ignored.
  - OFF: ring_ena=0 for OFF_CYCLES cycles. ring_tap is stable throughout, so tap changes never occur while enabled. Then go to SETTLE.
  - SETTLE: ring_ena=1 for SETTLE_CYCLES cycles. Rises are not counted. Then clear the edge counter and go to GATE.
  - GATE: ring_ena=1 for exactly GATE_CYCLES cycles.
    - Each cycle with a rise increments the counter.
    - At all-ones the counter holds and sets an internal ovf flag.
    - A rise detected in the GATE_CYCLES-th cycle is counted.
    - Then load meas_count/meas_ovf/meas_tap, assert meas_valid, and go to REPORT.
  - REPORT: ring_ena=0. meas_valid held and data stable until meas_valid & meas_ready. The handshake completes in the same cycle ready is seen; no combinational ready-to-valid path.
    - On acceptance, sweep mode with ring_tap<15: ring_tap+1, go to OFF.
    - Otherwise: go to IDLE, pulse done one cycle.
- meas_valid deasserts in the cycle after acceptance.
- Latency:
  - start to first meas_valid = 1 + OFF_CYCLES + SETTLE_CYCLES + GATE_CYCLES cycles.
  - Sweep after acceptance: each subsequent result follows acceptance by the same latency.
- ring_tap never wraps; the sweep ends after tap 15 is accepted.
- abort:
  - Any state except IDLE: next state IDLE, ring_ena=0, meas_valid=0.
  - No done pulse; counters cleared; ring_tap retains its value.
  - abort has priority over start and over a same-cycle handshake; that result is dropped.
- meas_ready while meas_valid=0 has no effect.
- Synchronizer is not cleared between taps. Stale activity is absorbed by SETTLE (>= 3 cycles).

Test Plan:
- Single tap, ring_div model toggling with a 10-clk period, GATE_CYCLES=1024, tap_sel=5.
  - Expect meas_count=102 or 103, meas_tap=5, ovf=0.
  - meas_valid rises exactly 1043 cycles after start (defaults).
  - done pulses one cycle after acceptance.
- Sweep with meas_ready tied 1.
  - Expect 16 results, meas_tap 0..15 in order.
  - ring_ena is low for >= OFF_CYCLES cycles before each tap change; ring_tap is never changed while ring_ena=1.
  - Exactly one done pulse.
- Backpressure: hold meas_ready=0 for 50 cycles in REPORT.
  - meas_valid, count and tap stay stable; ring_ena=0.
  - The next tap starts only after the ready handshake.
- Overflow: CNT_W=4, ring_div period 4 clk.
  - meas_count=15, meas_ovf=1.
  - The next tap's measurement starts with a cleared counter and ovf=0.
- Abort mid-GATE of tap 7 during a sweep.
  - Next cycle: IDLE, busy=0, ring_ena=0, no meas_valid, no done.
  - A subsequent start in single mode with tap_sel=3 measures correctly.
- Async reset mid-REPORT: assert rst_n low between clock edges.
  - Outputs go to 0 immediately, without a clock edge.
  - After release, start runs a normal measurement; start pulses while busy do not restart the sequence.
